// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared FSM encoding and sizing constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  localparam int REG_W = 4;
  localparam int MEM_WAIT_DEF = 6;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} mem_state_e;
endpackage

// File: rtl/sram_wait_fsm.sv
// sram_wait_fsm: counts out the SRAM access latency and freezes the pipeline until the access completes
module sram_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = MEM_WAIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_req,
  input  logic       sram_ready,
  output logic       mem_stall,
  output logic       mem_busy,
  output mem_state_e state
);
  mem_state_e state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end
  // DONE always falls back to IDLE so the same MEM instruction cannot re-trigger an access
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        state_d = mem_req ? WAIT : IDLE;
        wcnt_d  = mem_req ? 8'(MEM_WAIT_CYCLES - 1) : wcnt_q;
      end
      WAIT: begin
        state_d = (wcnt_q == '0 || sram_ready) ? DONE : WAIT;
        wcnt_d  = (wcnt_q == '0) ? '0 : wcnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  assign mem_stall = (state_q == IDLE && mem_req) || state_q == WAIT;
  assign mem_busy  = state_q != IDLE;
  assign state     = state_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with memory freeze,
// branch flush, data-hazard bubbles and saturating performance counters
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = MEM_WAIT_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             use_src1,
  input  logic             use_src2,
  input  logic             forward_en,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic             sram_ready,
  input  logic             branch_taken,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             freeze_back,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic mem_req, mem_stall, hz_exe, hz_mem, hazard, do_flush, do_bubble;
  mem_state_e mem_state;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d, flush_cnt_q, flush_cnt_d;
  assign mem_req = mem_r_en | mem_w_en;
  sram_wait_fsm #(.MEM_WAIT_CYCLES(MEM_WAIT_CYCLES)) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .sram_ready (sram_ready),
    .mem_stall  (mem_stall),
    .mem_busy   (mem_busy),
    .state      (mem_state)
  );
  assign hz_exe = exe_wb_en & ((use_src1 & (src1 == exe_dest)) | (use_src2 & (src2 == exe_dest)));
  assign hz_mem = mem_wb_en & ((use_src1 & (src1 == mem_dest)) | (use_src2 & (src2 == mem_dest)));
  // with forwarding only a load in EXE cannot be bypassed in time
  assign hazard = forward_en ? (hz_exe & exe_mem_r_en) : (hz_exe | hz_mem);
  assign do_flush  = ~mem_stall & branch_taken;
  assign do_bubble = ~mem_stall & ~branch_taken & hazard;
  assign freeze_pc    = mem_stall | do_bubble;
  assign freeze_if_id = mem_stall | do_bubble;
  assign flush_if_id  = do_flush;
  assign flush_id_ex  = do_flush | do_bubble;
  assign freeze_back  = mem_stall;
  assign stall_cnt_d  = stall_cnt_q + CNT_W'(mem_stall & ~&stall_cnt_q);
  assign bubble_cnt_d = bubble_cnt_q + CNT_W'(do_bubble & ~&bubble_cnt_q);
  assign flush_cnt_d  = flush_cnt_q + CNT_W'(do_flush & ~&flush_cnt_q);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  // the release cycle must let the pipeline advance
  a_done_no_stall: assert property (@(posedge clk) disable iff (rst) (mem_state == DONE) |-> !mem_stall);
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard-driven bench for the pipeline stall/flush sequencer
module tb_pipe_hazard_ctrl;
  localparam int CW = 8;
  localparam logic [5:0] C_NONE = 6'b000000;
  localparam logic [5:0] C_STL0 = 6'b110010;
  localparam logic [5:0] C_STL  = 6'b110011;
  localparam logic [5:0] C_DONE = 6'b000001;
  localparam logic [5:0] C_BUB  = 6'b110100;
  localparam logic [5:0] C_FLU  = 6'b001100;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic use_src1, use_src2, forward_en, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic mem_r_en, mem_w_en, sram_ready, branch_taken;
  logic freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back, mem_busy;
  logic [CW-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic [5:0] got, want;
  logic [5:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int exp_stall = 0, exp_bub = 0, exp_flu = 0;
  pipe_hazard_ctrl #(.MEM_WAIT_CYCLES(6), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use_src1(use_src1), .use_src2(use_src2),
    .forward_en(forward_en), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .sram_ready(sram_ready), .branch_taken(branch_taken), .freeze_pc(freeze_pc),
    .freeze_if_id(freeze_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .freeze_back(freeze_back), .mem_busy(mem_busy), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  assign got = {freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_back, mem_busy};
  function automatic logic [CW-1:0] sat(input int x);
    return (x > 255) ? 8'hFF : 8'(x);
  endfunction
  task automatic clear_inputs();
    {src1, src2, exe_dest, mem_dest} = '0;
    {use_src1, use_src2, forward_en, exe_wb_en, exe_mem_r_en, mem_wb_en} = '0;
    {mem_r_en, mem_w_en, sram_ready, branch_taken} = '0;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    n_chk++;
    if ({got, stall_cnt, bubble_cnt, flush_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got=%b/%0d/%0d/%0d exp=0", got, stall_cnt, bubble_cnt, flush_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    mem_r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(i == 0 ? C_STL0 : C_STL);
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL reset_pre cyc%0d got=%b exp=%b", i, got, want); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (mem_busy !== 1'b0 || stall_cnt !== '0 || bubble_cnt !== '0 || flush_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait got busy=%b stall=%0d exp busy=0 stall=0", mem_busy, stall_cnt);
    end
    mem_r_en = 1'b0;
    #1;
    rst = 1'b0;
    exp_stall = 0;
    exp_q.push_back(C_NONE);
    @(negedge clk);
    want = exp_q.pop_front();
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL reset_release got=%b exp=%b", got, want); end
    @(posedge clk); #1;
  endtask
  task automatic test_mem_wait(input bit rdy);
    int n_stall;
    n_stall = rdy ? 3 : 7;
    for (int i = 0; i < n_stall + 2; i++) begin
      mem_r_en = i < n_stall;
      sram_ready = rdy && i == 2;
      exp_q.push_back(i == 0 ? C_STL0 : i < n_stall ? C_STL : i == n_stall ? C_DONE : C_NONE);
      if (i < n_stall) exp_stall++;
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL mem_wait rdy%0d cyc%0d got=%b exp=%b", rdy, i, got, want); end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_chk++;
    if (stall_cnt !== sat(exp_stall)) begin
      n_fail++;
      $display("FAIL mem_wait_cnt rdy%0d got=%0d exp=%0d", rdy, stall_cnt, sat(exp_stall));
    end
  endtask
  task automatic test_hazard();
    logic [5:0] exp_tab[6] = '{C_BUB, C_NONE, C_BUB, C_NONE, C_BUB, C_NONE};
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      case (i)
        0, 1: begin forward_en = 1; exe_mem_r_en = (i == 0); exe_wb_en = 1; exe_dest = 5; src1 = 5; use_src1 = 1; end
        2, 3: begin mem_wb_en = 1; mem_dest = 2; src2 = 2; use_src2 = (i == 2); end
        4, 5: begin forward_en = (i == 5); exe_wb_en = 1; exe_dest = 9; src2 = 9; use_src2 = 1; end
        default: ;
      endcase
      exp_q.push_back(exp_tab[i]);
      if (exp_tab[i] == C_BUB) exp_bub++;
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL hazard case%0d got=%b exp=%b", i, got, want); end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_chk++;
    if (bubble_cnt !== sat(exp_bub)) begin n_fail++; $display("FAIL bubble_cnt got=%0d exp=%0d", bubble_cnt, sat(exp_bub)); end
  endtask
  task automatic test_branch();
    forward_en = 1; exe_mem_r_en = 1; exe_wb_en = 1; exe_dest = 3; src1 = 3; use_src1 = 1;
    branch_taken = 1;
    exp_q.push_back(C_FLU);
    exp_flu++;
    @(negedge clk);
    want = exp_q.pop_front();
    n_chk++;
    if (got !== want) begin n_fail++; $display("FAIL branch_vs_hazard got=%b exp=%b", got, want); end
    @(posedge clk); #1;
    clear_inputs();
    n_chk++;
    if (flush_cnt !== sat(exp_flu) || bubble_cnt !== sat(exp_bub)) begin
      n_fail++;
      $display("FAIL branch_cnts got=%0d/%0d exp=%0d/%0d", flush_cnt, bubble_cnt, sat(exp_flu), sat(exp_bub));
    end
    branch_taken = 1;
    for (int i = 0; i < 8; i++) begin
      mem_w_en = i < 7;
      exp_q.push_back(i == 0 ? C_STL0 : i < 7 ? C_STL : (C_FLU | C_DONE));
      if (i < 7) exp_stall++; else exp_flu++;
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL branch_in_stall cyc%0d got=%b exp=%b", i, got, want); end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_chk++;
    if (flush_cnt !== sat(exp_flu) || stall_cnt !== sat(exp_stall)) begin
      n_fail++;
      $display("FAIL branch_stall_cnts got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, sat(exp_flu), sat(exp_stall));
    end
  endtask
  task automatic test_saturate();
    for (int i = 0; i < 401; i++) begin
      mem_r_en = i < 400;
      exp_q.push_back(i == 400 ? C_NONE : (i % 8 == 0) ? C_STL0 : (i % 8 == 7) ? C_DONE : C_STL);
      if (i < 400 && i % 8 != 7) exp_stall++;
      @(negedge clk);
      want = exp_q.pop_front();
      n_chk++;
      if (got !== want) begin n_fail++; $display("FAIL saturate cyc%0d got=%b exp=%b", i, got, want); end
      @(posedge clk); #1;
    end
    clear_inputs();
    n_chk++;
    if (stall_cnt !== 8'hFF || stall_cnt !== sat(exp_stall)) begin
      n_fail++;
      $display("FAIL stall_sat got=%0d exp=%0d", stall_cnt, sat(exp_stall));
    end
    n_chk++;
    if (bubble_cnt !== sat(exp_bub) || flush_cnt !== sat(exp_flu)) begin
      n_fail++;
      $display("FAIL sat_others got=%0d/%0d exp=%0d/%0d", bubble_cnt, flush_cnt, sat(exp_bub), sat(exp_flu));
    end
  endtask
  initial begin
    test_reset();
    test_mem_wait(1'b0);
    test_mem_wait(1'b1);
    test_hazard();
    test_branch();
    test_saturate();
    n_chk++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives the hold and flush controls of the IF/ID and ID/EX pipeline registers and the PC.
- Detects load-use and RAW data hazards, and applies branch-taken flushes.
- Runs a multi-cycle SRAM wait state machine that freezes the whole pipeline while the MEM stage accesses memory.
- Keeps saturating performance counters for stalls, bubbles and flushes.

Parameters:
MEM_WAIT_CYCLES, 6, SRAM access latency in cycles; legal range 1..255.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
src1  in  4  Rn index of the instruction in ID
src2  in  4  Rm/Rd index of the instruction in ID
use_src1  in  1  the ID instruction reads src1
use_src2  in  1  the ID instruction reads src2
forward_en  in  1  forwarding unit enabled
exe_dest  in  4  destination register of the instruction in EXE
exe_wb_en  in  1  the EXE instruction writes back
exe_mem_r_en  in  1  the EXE instruction is a load
mem_dest  in  4  destination register of the instruction in MEM
mem_wb_en  in  1  the MEM instruction writes back
mem_r_en  in  1  load in MEM
mem_w_en  in  1  store in MEM
sram_ready  in  1  early completion from the SRAM controller
branch_taken  in  1  B flag of the EXE instruction
freeze_pc  out  1  PC holds its value
freeze_if_id  out  1  IF/ID register holds
flush_if_id  out  1  IF/ID register loads a bubble
flush_id_ex  out  1  ID/EX register loads a bubble (its flush input)
freeze_back  out  1  ID/EX, EX/MEM and MEM/WB registers hold
mem_busy  out  1  SRAM FSM is not IDLE
stall_cnt  out  CNT_W  cycles frozen by memory
bubble_cnt  out  CNT_W  bubbles inserted for data hazards
flush_cnt  out  CNT_W  branch flushes

Behaviour:
- Reset (asynchronous, at any time, including mid-access): FSM goes to IDLE, wait counter and all three performance counters go to 0. All control outputs are 0 unless mem_r_en or mem_w_en is 1, per the rules below.
- mem_req = mem_r_en | mem_w_en.
- FSM states: IDLE, WAIT, DONE (2-bit encoding).
  - IDLE: if mem_req, go to WAIT and load wcnt = MEM_WAIT_CYCLES-1.
  - WAIT: wcnt decrements each cycle. When wcnt==0 or sram_ready, go to DONE.
  - DONE: one cycle in which the pipeline advances; always returns to IDLE. This prevents re-triggering on the same MEM instruction.
- mem_stall (combinational) = (IDLE & mem_req) | WAIT.
  - The stall therefore begins in the same cycle the access appears.
  - With MEM_WAIT_CYCLES=N and no sram_ready, the access is stalled for N+1 cycles (IDLE plus N cycles in WAIT) and released in DONE.
  - mem_busy = state != IDLE.
- Data hazard (combinational):
  - hz_exe = exe_wb_en & ((use_src1 & src1==exe_dest) | (use_src2 & src2==exe_dest)).
  - hz_mem is the same test against mem_dest / mem_wb_en.
  - If forward_en=0: hazard = hz_exe | hz_mem.
  - If forward_en=1: hazard = hz_exe & exe_mem_r_en (load-use only).
- Output priority: memory freeze > branch > hazard.
  - mem_stall=1: freeze_pc = freeze_if_id = freeze_back = 1; both flushes 0. A pending branch or hazard is re-evaluated once the freeze releases.
  - else branch_taken=1: flush_if_id = flush_id_ex = 1; freezes 0, so the PC loads the branch target. Any simultaneous hazard is ignored because the ID instruction is discarded.
  - else hazard=1: freeze_pc = freeze_if_id = 1 and flush_id_ex = 1 (bubble); freeze_back = 0.
  - else all controls are 0.
- Counters: registered, saturating at all-ones, never wrap.
  - stall_cnt increments on every mem_stall cycle.
  - bubble_cnt increments on every cycle where the hazard branch of the priority chain is taken.
  - flush_cnt increments on every cycle where the branch branch of the priority chain is taken.
- All control outputs are combinational from the FSM state plus inputs, with no extra latency.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state typedef and encodings (IDLE=0, WAIT=1, DONE=2);
  - the register-index width constant (4);
  - the default MEM_WAIT_CYCLES.
- Natural sub-module: sram_wait_fsm. It takes mem_req and sram_ready and produces mem_stall, mem_busy and state.
- The hazard compare, priority mux and counters stay in the top level.

Test Plan:
- Reset asserted mid-WAIT (wcnt=3) -> mem_busy=0 and all counters 0 immediately. After release with mem_req=0, all controls are 0.
- Load in MEM, MEM_WAIT_CYCLES=6, sram_ready=0 -> freeze_back=1 for exactly 7 cycles. DONE follows with freeze_back=0, then IDLE. stall_cnt=7.
- Same access with sram_ready pulsed in the 2nd WAIT cycle -> DONE on the next cycle; 3 stall cycles in total.
- forward_en=1, exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, src1=5, use_src1=1 -> freeze_pc=1, freeze_if_id=1, flush_id_ex=1; bubble_cnt +1. Repeat with exe_mem_r_en=0 -> no stall.
- forward_en=0, mem_wb_en=1, mem_dest=2, src2=2, use_src2=1 -> bubble. Same case with use_src2=0 -> no bubble.
- branch_taken and hazard together -> both flushes 1, freeze_pc=0, flush_cnt +1, bubble_cnt unchanged. branch_taken during mem_stall -> no flush until the freeze releases. Force 2^CNT_W-1 stall cycles -> stall_cnt holds at all-ones.
